// File: rtl/conv_window_gen.sv
`timescale 1ns/1ps
// Sliding K_H x K_W window generator over a raster-order pixel stream (no padding, stride 1).
// Latency: 1 cycle from the accepting edge to win_valid; one pixel per cycle at full throughput.
// Backpressure: single-slot output register; in_ready = !win_valid || win_ready (pass-through on pop).
module conv_window_gen #(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int DATA_WIDTH = 9,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DATA_WIDTH-1:0]       pixel_in,
    output logic                               win_valid,
    input  logic                               win_ready,
    output logic [K_H*K_W*DATA_WIDTH-1:0]      win_flat,
    output logic                               win_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = K_H * K_W * DATA_WIDTH;

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  ready_en_q;
    logic                  win_valid_q;
    logic                  win_last_q;
    logic [FW-1:0]         win_flat_q, win_flat_d;

    // Line buffer 0 holds the oldest row; buffer K_H-2 the row just above the current one.
    logic [DATA_WIDTH-1:0] lb_q  [K_H-1][IMG_W];
    logic [DATA_WIDTH-1:0] win_q [K_H][K_W];
    logic [DATA_WIDTH-1:0] win_d [K_H][K_W];
    logic [DATA_WIDTH-1:0] col_new [K_H];

    logic accept;
    logic emit;
    logic frame_end;

    assign in_ready  = ready_en_q && (!win_valid_q || win_ready);
    assign accept    = in_valid && in_ready;
    assign frame_end = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    // A window is complete only once this row has supplied K_W columns, so no
    // window ever straddles a row wrap.
    assign emit      = accept && (row_q >= RW'(K_H - 1)) && (col_q >= CW'(K_W - 1));

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_flat  = win_flat_q;

    // New rightmost window column: buffered rows above, incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K_H; r++) begin
            col_new[r] = '0;
        end
        for (int r = 0; r < K_H - 1; r++) begin
            col_new[r] = lb_q[r][col_q];
        end
        col_new[K_H-1] = pixel_in;
    end

    // Next window contents (shift left by one column) and its flattened form.
    always_comb begin
        win_flat_d = '0;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
                win_d[r][c] = (c < K_W - 1) ? win_q[r][c+1] : col_new[r];
                win_flat_d[(r*K_W+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters and the post-reset input enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ready_en_q <= 1'b1;
        end
    end

    // Line buffers and window shift register; read-before-write at the same column index.
    // Contents are never exposed before being overwritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K_H - 2; r++) begin
                lb_q[r][col_q] <= lb_q[r+1][col_q];
            end
            lb_q[K_H-2][col_q] <= pixel_in;
            for (int r = 0; r < K_H; r++) begin
                for (int c = 0; c < K_W; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

    // Output slot: load on a completed window, clear on pop, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_flat_q  <= '0;
        end else if (emit) begin
            win_valid_q <= 1'b1;
            win_last_q  <= frame_end;
            win_flat_q  <= win_flat_d;
        end else if (win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps
// Directed bench for conv_window_gen on a 5x5 frame with a 3x3 window.
// Windows are compared in order against a reference built from the pixel generator.
// Covers latency, row wrap, stall hold, random gaps, sign pass-through and mid-frame reset.
module tb_conv_window_gen;

    localparam int KH = 3;
    localparam int KW = 3;
    localparam int DW = 9;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int FWID = KH * KW * DW;
    localparam int NPX = IW * IH;
    localparam int NWIN = (IH - KH + 1) * (IW - KW + 1);
    localparam int LIMIT = 3000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    pixel_in;
    logic             win_valid;
    logic             win_ready;
    logic [FWID-1:0]  win_flat;
    logic             win_last;

    int checks = 0;
    int errors = 0;

    conv_window_gen #(
        .K_H(KH), .K_W(KW), .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pixel_in(pixel_in),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_flat(win_flat),
        .win_last(win_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Pixel value for stream position n (n spans consecutive frames).
    function automatic logic [DW-1:0] pix(input int seed, input int n);
        int f;
        int idx;
        f   = n / NPX;
        idx = n % NPX;
        case (seed)
            0: return DW'(n);
            1: return DW'(idx * 37 + f * 101 + 200);
            2: return DW'(idx + 300);
            default: begin
                if (idx == 0)       return 9'h100;
                else if (idx == 12) return 9'h0FF;
                else                return DW'(idx);
            end
        endcase
    endfunction

    // Reference window k of the stream: {win_last, win_flat}.
    function automatic logic [FWID:0] exp_win(input int seed, input int k);
        logic [FWID-1:0] flat;
        int f, w, r, c;
        f = k / NWIN;
        w = k % NWIN;
        r = w / (IW - KW + 1) + KH - 1;
        c = w % (IW - KW + 1) + KW - 1;
        flat = '0;
        for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
                flat[(i*KW+j)*DW +: DW] = pix(seed, f*NPX + (r-KH+1+i)*IW + (c-KW+1+j));
        return {(w == NWIN - 1), flat};
    endfunction

    // Stream nfr frames. vmode: 0 = in_valid constant, 1 = random gaps.
    // rmode: 0 = win_ready constant, 1 = random, 2 = stall first window for 4 cycles.
    task automatic run(input string tag, input int seed, input int nfr, input int vmode,
                       input int rmode, output logic [FWID-1:0] first_flat,
                       output logic [FWID-1:0] last_flat);
        int sent, got, lasts, cyc, stall, acc12, first_v;
        sent = 0; got = 0; lasts = 0; cyc = 0; stall = 0; acc12 = -1; first_v = -1;
        first_flat = '0;
        last_flat  = '0;
        while ((sent < nfr*NPX || got < nfr*NWIN) && cyc < LIMIT) begin
            @(negedge clk);
            in_valid = (sent < nfr*NPX) && (vmode == 0 || $urandom_range(0, 3) != 0);
            pixel_in = pix(seed, sent);
            if (rmode == 0)      win_ready = 1'b1;
            else if (rmode == 1) win_ready = 1'($urandom_range(0, 1));
            else begin
                win_ready = !(win_valid && got == 0 && stall < 4);
                if (!win_ready) stall++;
            end
            #1;
            if (rmode == 2 && !win_ready) begin
                check({tag, " stall in_ready"}, 128'(in_ready), 128'(0));
                check({tag, " stall hold"}, 128'({win_last, win_flat}), 128'(exp_win(seed, 0)));
            end
            if (win_valid && win_ready) begin
                check({tag, " window"}, 128'({win_last, win_flat}), 128'(exp_win(seed, got)));
                if (win_last) lasts++;
                if (got == 0) begin
                    first_v    = cyc;
                    first_flat = win_flat;
                end
                last_flat = win_flat;
                got++;
            end
            if (in_valid && in_ready) begin
                if (sent == 12) acc12 = cyc;
                sent++;
            end
            cyc++;
        end
        check({tag, " timeout"}, 128'(cyc < LIMIT), 128'(1));
        check({tag, " window count"}, 128'(got), 128'(nfr*NWIN));
        check({tag, " last count"}, 128'(lasts), 128'(nfr));
        if (vmode == 0 && rmode == 0)
            check({tag, " first latency"}, 128'(first_v), 128'(acc12 + 1));
        if (rmode == 2)
            check({tag, " stall cycles"}, 128'(stall), 128'(4));
        @(negedge clk);
        in_valid  = 1'b0;
        win_ready = 1'b1;
        #1;
        check({tag, " drained"}, 128'(win_valid), 128'(0));
    endtask

    function automatic logic [FWID-1:0] pack9(input int v0, input int v1, input int v2,
                                              input int v3, input int v4, input int v5,
                                              input int v6, input int v7, input int v8);
        int vals[9];
        logic [FWID-1:0] flat;
        vals = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        flat = '0;
        for (int i = 0; i < 9; i++) flat[i*DW +: DW] = DW'(vals[i]);
        return flat;
    endfunction

    initial begin
        logic [FWID-1:0] ff, lf;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        win_ready = 1'b0;
        pixel_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", 128'(in_ready), 128'(0));
        check("reset win_valid", 128'(win_valid), 128'(0));
        check("reset win_last", 128'(win_last), 128'(0));
        check("reset win_flat", 128'(win_flat), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post-reset in_ready", 128'(in_ready), 128'(1));

        // Basic frame, pixel = row*5+col, full throughput.
        run("basic", 0, 1, 0, 0, ff, lf);
        check("basic first window", 128'(ff), 128'(pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)));
        check("basic last window", 128'(lf), 128'(pack9(12, 13, 14, 17, 18, 19, 22, 23, 24)));

        // Backpressure on the first window (frame counters wrapped, so this is a fresh frame).
        run("stall", 0, 1, 0, 2, ff, lf);
        check("stall first window", 128'(ff), 128'(pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)));

        // Random source gaps and random consumer readiness over two frames.
        run("random", 1, 2, 1, 1, ff, lf);

        // Signed extremes must pass bit-exact.
        run("sign", 3, 1, 0, 0, ff, lf);
        check("sign elem(0,0)", 128'(ff[0 +: DW]), 128'(9'h100));
        check("sign elem(2,2)", 128'(ff[8*DW +: DW]), 128'(9'h0FF));

        // Mid-frame reset after 13 pixels.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            win_ready = 1'b1;
            pixel_in  = pix(2, i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset win_valid", 128'(win_valid), 128'(0));
        check("midreset in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run("after reset", 0, 1, 0, 0, ff, lf);
        check("after reset first", 128'(ff), 128'(pack9(0, 1, 2, 5, 6, 7, 10, 11, 12)));

        // Two back-to-back frames with no idle cycle.
        run("b2b", 1, 2, 0, 0, ff, lf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
